// File: rtl/ym3438_pkg.sv
// ym3438_pkg: slot bus geometry, operator group encoding and slot decode helpers.
package ym3438_pkg;

    localparam int NUM_SLOTS    = 24;
    localparam int NUM_CH       = 6;
    localparam int SLOTS_PER_OP = 6;

    typedef enum logic [1:0] {
        OP4 = 2'd0,
        OP1 = 2'd1,
        OP3 = 2'd2,
        OP2 = 2'd3
    } op_grp_t;

    function automatic logic [2:0] slot_to_ch(input logic [4:0] s);
        logic [4:0] m;
        m = s % 5'(SLOTS_PER_OP);
        return m[2:0];
    endfunction

    function automatic op_grp_t slot_to_grp(input logic [4:0] s);
        logic [4:0] q;
        q = s / 5'(SLOTS_PER_OP);
        return op_grp_t'(q[1:0]);
    endfunction

endpackage

// File: rtl/ym3438_sat_acc.sv
// ym3438_sat_acc: sign-extend one operator sample, add it to a channel partial sum and clamp to SAT_W.
module ym3438_sat_acc #(
    parameter int DATA_W = 14,
    parameter int SAT_W  = 14
) (
    input  logic [SAT_W-1:0]  i_acc,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_en,
    input  logic              i_first,
    output logic [SAT_W-1:0]  o_sum
);

    // Three guard bits cover SAT_W up to DATA_W+2 plus the carry of the add.
    localparam int SUM_W = DATA_W + 3;
    localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-SAT_W+1){1'b0}}, {(SAT_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] MIN_V = {{(SUM_W-SAT_W+1){1'b1}}, {(SAT_W-1){1'b0}}};

    logic signed [SUM_W-1:0] w_acc;
    logic signed [SUM_W-1:0] w_data;
    logic signed [SUM_W-1:0] w_sum;

    assign w_acc  = i_first ? '0 : {{(SUM_W-SAT_W){i_acc[SAT_W-1]}}, i_acc};
    assign w_data = i_en ? {{(SUM_W-DATA_W){i_data[DATA_W-1]}}, i_data} : '0;
    assign w_sum  = w_acc + w_data;
    assign o_sum  = (w_sum > MAX_V) ? MAX_V[SAT_W-1:0] :
                    (w_sum < MIN_V) ? MIN_V[SAT_W-1:0] : w_sum[SAT_W-1:0];

endmodule

// File: rtl/ym3438_slot_decoder.sv
// ym3438_slot_decoder: rebuilds the 24-slot operator bus count from sync, sums contributing
// operators per channel with saturation and hands out six-channel frames on a valid/ready port.
module ym3438_slot_decoder
    import ym3438_pkg::*;
#(
    parameter int DATA_W = 14,
    parameter int SAT_W  = 14,
    parameter int OUT_W  = 16
) (
    input  logic                MCLK,
    input  logic                IC,
    input  logic                slot_en,
    input  logic                sync,
    input  logic [DATA_W-1:0]   op_data,
    input  logic                out_en,
    output logic [6*OUT_W-1:0]  frame_data,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                locked,
    output logic                sync_err,
    output logic                overrun
);

    logic [4:0]       r_slot;
    logic [SAT_W-1:0] r_acc [NUM_CH];
    logic [SAT_W-1:0] r_stg [NUM_CH];

    logic [4:0]         w_cur;
    logic [2:0]         w_ch;
    op_grp_t            w_grp;
    logic               w_act;
    logic               w_last;
    logic               w_resync;
    logic               w_free;
    logic [SAT_W-1:0]   w_sum;
    logic [6*OUT_W-1:0] w_frame;

    // A sync strobe always re-labels the presented slot as slot 0.
    assign w_cur    = sync ? '0 : r_slot;
    assign w_ch     = slot_to_ch(w_cur);
    assign w_grp    = slot_to_grp(w_cur);
    assign w_act    = slot_en & (locked | sync);
    assign w_last   = w_act & (w_cur == 5'(NUM_SLOTS-1));
    assign w_resync = slot_en & sync & locked & (r_slot != '0);
    assign w_free   = ~frame_valid | frame_ready;

    ym3438_sat_acc #(
        .DATA_W (DATA_W),
        .SAT_W  (SAT_W)
    ) u_sat_acc (
        .i_acc   (r_acc[w_ch]),
        .i_data  (op_data),
        .i_en    (out_en),
        .i_first (w_grp == OP4),
        .o_sum   (w_sum)
    );

    // The last channel's final sum is still in flight at frame end, so bypass it into the frame.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        logic [SAT_W-1:0] w_word;
        assign w_word = (w_ch == 3'(g)) ? w_sum : r_stg[g];
        assign w_frame[g*OUT_W +: OUT_W] = {{(OUT_W-SAT_W){w_word[SAT_W-1]}}, w_word};
    end

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            r_slot      <= '0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            overrun     <= 1'b0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_acc[c] <= '0;
                r_stg[c] <= '0;
            end
        end else begin
            if (frame_valid & frame_ready)
                frame_valid <= 1'b0;
            if (slot_en) begin
                r_slot <= (w_cur == 5'(NUM_SLOTS-1)) ? '0 : w_cur + 5'd1;
                if (sync)
                    locked <= 1'b1;
                if (w_resync)
                    sync_err <= 1'b1;
            end
            if (w_act) begin
                r_acc[w_ch] <= w_sum;
                if (w_grp == OP2)
                    r_stg[w_ch] <= w_sum;
            end
            if (w_last) begin
                if (w_free) begin
                    frame_data  <= w_frame;
                    frame_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ym3438_slot_decoder.sv
// tb_ym3438_slot_decoder: directed scenarios for the slot decoder with hand-computed channel sums.
module tb_ym3438_slot_decoder;

    logic        MCLK = 1'b0;
    logic        IC = 1'b0;
    logic        slot_en = 1'b0;
    logic        sync = 1'b0;
    logic        out_en = 1'b0;
    logic        frame_ready = 1'b0;
    logic [13:0] op_data = '0;
    logic [95:0] frame_data;
    logic        frame_valid;
    logic        locked;
    logic        sync_err;
    logic        overrun;

    logic [13:0] v_data [24];
    logic        v_en [24];
    int          n_pass = 0;
    int          n_total = 0;

    ym3438_slot_decoder dut (
        .MCLK        (MCLK),
        .IC          (IC),
        .slot_en     (slot_en),
        .sync        (sync),
        .op_data     (op_data),
        .out_en      (out_en),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .locked      (locked),
        .sync_err    (sync_err),
        .overrun     (overrun)
    );

    always #5 MCLK = ~MCLK;

    function automatic logic [15:0] ch(input int k);
        return frame_data[k*16 +: 16];
    endfunction

    task automatic idle;
        @(posedge MCLK);
        #1;
    endtask

    task automatic send_slot(input logic s, input logic [13:0] d, input logic e);
        slot_en = 1'b1;
        sync    = s;
        op_data = d;
        out_en  = e;
        @(posedge MCLK);
        #1;
        slot_en = 1'b0;
        sync    = 1'b0;
    endtask

    task automatic send_range(input int a, input int b);
        for (int i = a; i <= b; i++)
            send_slot(i == 0, v_data[i], v_en[i]);
    endtask

    task automatic set_frame(input logic [13:0] d, input logic e);
        for (int i = 0; i < 24; i++) begin
            v_data[i] = d;
            v_en[i]   = e;
        end
    endtask

    task automatic test_reset;
        IC = 1'b0;
        repeat (2) @(posedge MCLK);
        #1;
        n_total++; if (frame_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", frame_valid); else n_pass++;
        n_total++; if (frame_data !== 96'd0) $display("FAIL reset_data got %h want 0", frame_data); else n_pass++;
        n_total++; if (locked !== 1'b0) $display("FAIL reset_locked got %b want 0", locked); else n_pass++;
        n_total++; if (sync_err !== 1'b0) $display("FAIL reset_sync_err got %b want 0", sync_err); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else n_pass++;
        IC = 1'b1;
        idle();
    endtask

    task automatic test_basic;
        frame_ready = 1'b1;
        set_frame(14'd100, 1'b1);
        send_range(0, 11);
        repeat (3) idle();
        send_range(12, 22);
        n_total++; if (frame_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", frame_valid); else n_pass++;
        n_total++; if (locked !== 1'b1) $display("FAIL basic_locked got %b want 1", locked); else n_pass++;
        send_slot(1'b0, v_data[23], v_en[23]);
        n_total++; if (frame_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", frame_valid); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            n_total++; if (ch(k) !== 16'd400) $display("FAIL basic_ch%0d got %0d want 400", k, $signed(ch(k))); else n_pass++;
        end
        idle();
        n_total++; if (frame_valid !== 1'b0) $display("FAIL basic_drop got %b want 0", frame_valid); else n_pass++;
    endtask

    task automatic test_saturation;
        frame_ready = 1'b1;
        set_frame(14'd0, 1'b1);
        v_data[2] = 14'h1FFF; v_data[8] = 14'h1FFF; v_data[14] = 14'h1FFF; v_data[20] = 14'h1FFF;
        v_data[3] = 14'h1FFF; v_data[9] = 14'h1FFF; v_data[15] = 14'h2000; v_data[21] = 14'h2000;
        v_data[4] = 14'h1FFF; v_data[10] = 14'd1;   v_data[16] = 14'h3FFF; v_data[22] = 14'd0;
        send_range(0, 23);
        n_total++; if (frame_valid !== 1'b1) $display("FAIL sat_valid got %b want 1", frame_valid); else n_pass++;
        n_total++; if (ch(2) !== 16'h1FFF) $display("FAIL sat_pos_ch2 got %0d want 8191", $signed(ch(2))); else n_pass++;
        n_total++; if (ch(3) !== 16'hE000) $display("FAIL sat_step_ch3 got %0d want -8192", $signed(ch(3))); else n_pass++;
        n_total++; if (ch(4) !== 16'd8190) $display("FAIL sat_step_ch4 got %0d want 8190", $signed(ch(4))); else n_pass++;
        n_total++; if (ch(0) !== 16'd0) $display("FAIL sat_ch0 got %0d want 0", $signed(ch(0))); else n_pass++;
        idle();
        set_frame(14'd0, 1'b1);
        v_data[2] = 14'h2000; v_data[8] = 14'h2000; v_data[14] = 14'h2000; v_data[20] = 14'h2000;
        send_range(0, 23);
        n_total++; if (ch(2) !== 16'hE000) $display("FAIL sat_neg_ch2 got %0d want -8192", $signed(ch(2))); else n_pass++;
        idle();
    endtask

    task automatic test_group0;
        frame_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            v_data[i] = (i < 6) ? 14'(i) : 14'(1000 + i);
            v_en[i]   = (i < 6);
        end
        send_range(0, 23);
        for (int k = 0; k < 6; k++) begin
            n_total++; if (ch(k) !== 16'(k)) $display("FAIL grp0_ch%0d got %0d want %0d", k, $signed(ch(k)), k); else n_pass++;
        end
        idle();
    endtask

    task automatic test_back_to_back;
        frame_ready = 1'b0;
        set_frame(14'd10, 1'b1);
        send_range(0, 23);
        n_total++; if (frame_valid !== 1'b1 || ch(0) !== 16'd40) $display("FAIL b2b_first got v=%b ch0=%0d want v=1 ch0=40", frame_valid, $signed(ch(0))); else n_pass++;
        set_frame(14'd7, 1'b1);
        send_range(0, 22);
        n_total++; if (frame_valid !== 1'b1 || ch(0) !== 16'd40) $display("FAIL b2b_hold got v=%b ch0=%0d want v=1 ch0=40", frame_valid, $signed(ch(0))); else n_pass++;
        frame_ready = 1'b1;
        send_slot(1'b0, v_data[23], v_en[23]);
        n_total++; if (frame_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", frame_valid); else n_pass++;
        n_total++; if (ch(0) !== 16'd28 || ch(5) !== 16'd28) $display("FAIL b2b_data got ch0=%0d ch5=%0d want 28", $signed(ch(0)), $signed(ch(5))); else n_pass++;
        n_total++; if (overrun !== 1'b0) $display("FAIL b2b_overrun got %b want 0", overrun); else n_pass++;
        idle();
        n_total++; if (frame_valid !== 1'b0) $display("FAIL b2b_drop got %b want 0", frame_valid); else n_pass++;
    endtask

    task automatic test_overrun;
        frame_ready = 1'b0;
        set_frame(14'd50, 1'b1);
        send_range(0, 23);
        n_total++; if (frame_valid !== 1'b1 || ch(0) !== 16'd200) $display("FAIL ovr_first got v=%b ch0=%0d want v=1 ch0=200", frame_valid, $signed(ch(0))); else n_pass++;
        set_frame(14'(-30), 1'b1);
        send_range(0, 23);
        n_total++; if (frame_valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", frame_valid); else n_pass++;
        n_total++; if (ch(0) !== 16'd200 || ch(5) !== 16'd200) $display("FAIL ovr_held got ch0=%0d ch5=%0d want 200", $signed(ch(0)), $signed(ch(5))); else n_pass++;
        n_total++; if (overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", overrun); else n_pass++;
        frame_ready = 1'b1;
        idle();
        n_total++; if (frame_valid !== 1'b0) $display("FAIL ovr_drop got %b want 0", frame_valid); else n_pass++;
        n_total++; if (overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", overrun); else n_pass++;
    endtask

    task automatic test_resync;
        frame_ready = 1'b1;
        set_frame(14'd100, 1'b1);
        send_range(0, 9);
        n_total++; if (sync_err !== 1'b0) $display("FAIL rs_pre_err got %b want 0", sync_err); else n_pass++;
        send_slot(1'b1, 14'd25, 1'b1);
        n_total++; if (sync_err !== 1'b1) $display("FAIL rs_err got %b want 1", sync_err); else n_pass++;
        set_frame(14'd25, 1'b1);
        send_range(1, 22);
        n_total++; if (frame_valid !== 1'b0) $display("FAIL rs_partial got %b want 0", frame_valid); else n_pass++;
        send_slot(1'b0, v_data[23], v_en[23]);
        n_total++; if (frame_valid !== 1'b1) $display("FAIL rs_valid got %b want 1", frame_valid); else n_pass++;
        for (int k = 0; k < 6; k++) begin
            n_total++; if (ch(k) !== 16'd100) $display("FAIL rs_ch%0d got %0d want 100", k, $signed(ch(k))); else n_pass++;
        end
        idle();
    endtask

    task automatic test_async_reset;
        frame_ready = 1'b0;
        set_frame(14'd100, 1'b1);
        send_range(0, 23);
        n_total++; if (frame_valid !== 1'b1) $display("FAIL ar_pre_valid got %b want 1", frame_valid); else n_pass++;
        send_range(0, 5);
        #2;
        IC = 1'b0;
        #1;
        n_total++; if (frame_valid !== 1'b0) $display("FAIL ar_valid got %b want 0", frame_valid); else n_pass++;
        n_total++; if (frame_data !== 96'd0) $display("FAIL ar_data got %h want 0", frame_data); else n_pass++;
        n_total++; if (locked !== 1'b0) $display("FAIL ar_locked got %b want 0", locked); else n_pass++;
        n_total++; if (sync_err !== 1'b0 || overrun !== 1'b0) $display("FAIL ar_sticky got err=%b ovr=%b want 0 0", sync_err, overrun); else n_pass++;
        @(negedge MCLK);
        IC = 1'b1;
        frame_ready = 1'b1;
        idle();
        for (int i = 0; i < 24; i++)
            send_slot(1'b0, 14'd100, 1'b1);
        n_total++; if (frame_valid !== 1'b0 || locked !== 1'b0) $display("FAIL ar_unlocked got v=%b lk=%b want 0 0", frame_valid, locked); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_group0();
        test_back_to_back();
        test_overrun();
        test_resync();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
